// File: rtl/f_fetch_seq.sv
// f_fetch_seq: F-stage fetch sequencer for the 5-stage MIPS pipeline.
// Owns the F-stage PC, drives a stateless req/ack instruction-memory port,
// holds the fetched word while D is stalled, and redirects on flush.
module f_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] npc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_pc,
  output logic [31:0] F_instr,
  output logic        F_valid,
  output logic        F_exc_adel
);

  // FETCH: pc_q names an instruction not yet received; HOLD: F holds a valid word.
  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        adel_q, adel_d;
  logic        accept;

  // Misaligned or outside the instruction window. Also catches PC wrap-around,
  // since a wrapped PC lands below IMEM_LO.
  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < IMEM_LO) || (a > IMEM_HI);
  endfunction

  assign F_valid    = (state_q == S_HOLD);
  assign F_pc       = pc_q;
  assign F_instr    = instr_q;
  assign F_exc_adel = adel_q;
  assign accept     = F_valid & ~stall & ~flush;

  // Next-state, memory request and F-register update logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    adel_d    = adel_q;
    imem_req  = 1'b0;
    imem_addr = pc_q;

    if (flush) begin
      // Redirect wins over everything except reset; a same-cycle ack is dropped.
      state_d = S_FETCH;
      pc_d    = flush_pc;
      instr_d = '0;
      adel_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (bad_addr(pc_q)) begin
            // Never touch memory for an illegal address; deliver a faulted nop.
            state_d = S_HOLD;
            instr_d = '0;
            adel_d  = 1'b1;
          end else begin
            imem_req  = 1'b1;
            imem_addr = pc_q;
            if (imem_ack) begin
              state_d = S_HOLD;
              instr_d = imem_rdata;
              adel_d  = 1'b0;
            end
          end
        end

        S_HOLD: begin
          if (accept) begin
            pc_d = npc;
            if (bad_addr(npc)) begin
              instr_d = '0;
              adel_d  = 1'b1;
            end else begin
              // Request the next word in the same cycle D takes the current one,
              // so a zero-wait memory sustains one instruction per cycle.
              imem_req  = 1'b1;
              imem_addr = npc;
              if (imem_ack) begin
                instr_d = imem_rdata;
                adel_d  = 1'b0;
              end else begin
                state_d = S_FETCH;
                instr_d = '0;
                adel_d  = 1'b0;
              end
            end
          end
        end

        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // State and F-stage registers; reset abandons any outstanding fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      adel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      adel_q  <= adel_d;
    end
  end

endmodule

// File: tb/tb_f_fetch_seq.sv
// tb_f_fetch_seq: directed vector table for the fetch sequencer followed by
// randomized traffic checked against a behavioural model of F-stage contents.
module tb_f_fetch_seq;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] LO     = 32'h0000_3000;
  localparam logic [31:0] HI     = 32'h0000_6FFC;
  localparam logic [31:0] MASK   = 32'hFFFF_0000;
  localparam int          NVEC   = 27;
  localparam int          NRAND  = 3000;

  logic        clk = 1'b0;
  logic        reset, stall, flush, imem_ack;
  logic [31:0] npc, flush_pc, imem_rdata;
  logic        imem_req, F_valid, F_exc_adel;
  logic [31:0] imem_addr, F_pc, F_instr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  f_fetch_seq dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .npc        (npc),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .F_pc       (F_pc),
    .F_instr    (F_instr),
    .F_valid    (F_valid),
    .F_exc_adel (F_exc_adel)
  );

  typedef struct {
    logic        rst, stl, fl;
    logic [31:0] fpc, np;
    logic        ack;
    logic [31:0] rd;
    logic        cc;      // check combinational request outputs this cycle
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] epc, einstr;
    logic        eadel;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic vec_t mk(
    input logic rst, input logic stl, input logic fl, input logic [31:0] fpc,
    input logic [31:0] np, input logic ack, input logic [31:0] rd,
    input logic cc, input logic ereq, input logic [31:0] eaddr,
    input logic evld, input logic [31:0] epc, input logic [31:0] einstr,
    input logic eadel);
    vec_t v;
    v.rst = rst; v.stl = stl; v.fl = fl; v.fpc = fpc; v.np = np;
    v.ack = ack; v.rd = rd; v.cc = cc; v.ereq = ereq; v.eaddr = eaddr;
    v.evld = evld; v.epc = epc; v.einstr = einstr; v.eadel = eadel;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < LO) || (a > HI);
  endfunction

  function automatic logic [31:0] legal_pc();
    return LO + ({20'd0, 12'($urandom_range(0, 4095))} << 2);
  endfunction

  function automatic logic [31:0] any_pc();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return legal_pc() | 32'd2;
    if (sel == 1) return HI + 32'd4;
    if (sel == 2) return LO - 32'd4;
    return legal_pc();
  endfunction

  // Behavioural model: what F currently holds, and whether adel is defined.
  logic        m_vld;
  logic [31:0] m_pc, m_instr;
  logic        m_adel, m_adel_chk;

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; imem_ack = 1'b0;
    npc = '0; flush_pc = '0; imem_rdata = '0;

    //           rst stl fl fpc           np            ack rd                 cc ereq eaddr         vld epc           einstr        adel
    tbl[0]  = mk(0,  0,  0, 32'h0,        32'h0,        1,  32'hFFFF_3000,     1, 1,   32'h0000_3000, 0, 32'h0000_3000, 32'h0,        0);
    tbl[1]  = mk(0,  0,  0, 32'h0,        32'h0000_3004, 1, 32'hFFFF_3004,     1, 1,   32'h0000_3004, 1, 32'h0000_3000, 32'hFFFF_3000, 0);
    tbl[2]  = mk(0,  0,  0, 32'h0,        32'h0000_3008, 1, 32'hFFFF_3008,     1, 1,   32'h0000_3008, 1, 32'h0000_3004, 32'hFFFF_3004, 0);
    tbl[3]  = mk(0,  1,  0, 32'h0,        32'h0000_3040, 1, 32'h1234_5678,     1, 0,   32'h0,         1, 32'h0000_3008, 32'hFFFF_3008, 0);
    tbl[4]  = mk(0,  1,  0, 32'h0,        32'h0000_3040, 1, 32'h1234_5678,     1, 0,   32'h0,         1, 32'h0000_3008, 32'hFFFF_3008, 0);
    tbl[5]  = mk(0,  1,  0, 32'h0,        32'h0000_3040, 1, 32'h1234_5678,     1, 0,   32'h0,         1, 32'h0000_3008, 32'hFFFF_3008, 0);
    tbl[6]  = mk(0,  0,  0, 32'h0,        32'h0000_3040, 1, 32'hFFFF_3040,     1, 1,   32'h0000_3040, 1, 32'h0000_3008, 32'hFFFF_3008, 0);
    tbl[7]  = mk(0,  0,  0, 32'h0,        32'h0000_3044, 0, 32'hDEAD_0001,     1, 1,   32'h0000_3044, 1, 32'h0000_3040, 32'hFFFF_3040, 0);
    tbl[8]  = mk(0,  0,  0, 32'h0,        32'h0,        0,  32'hDEAD_0002,     1, 1,   32'h0000_3044, 0, 32'h0000_3044, 32'h0,        0);
    tbl[9]  = mk(0,  0,  0, 32'h0,        32'h0,        1,  32'hFFFF_3044,     1, 1,   32'h0000_3044, 0, 32'h0000_3044, 32'h0,        0);
    tbl[10] = mk(0,  0,  0, 32'h0,        32'h0000_3002, 1, 32'hDEAD_0003,     1, 0,   32'h0,         1, 32'h0000_3044, 32'hFFFF_3044, 0);
    tbl[11] = mk(0,  1,  0, 32'h0,        32'h0000_3002, 1, 32'hDEAD_0004,     1, 0,   32'h0,         1, 32'h0000_3002, 32'h0,        1);
    tbl[12] = mk(0,  0,  0, 32'h0,        32'h0000_7000, 1, 32'hDEAD_0005,     1, 0,   32'h0,         1, 32'h0000_3002, 32'h0,        1);
    tbl[13] = mk(0,  1,  0, 32'h0,        32'h0000_7000, 1, 32'hDEAD_0006,     1, 0,   32'h0,         1, 32'h0000_7000, 32'h0,        1);
    tbl[14] = mk(0,  0,  0, 32'h0,        32'h0000_3100, 0, 32'hDEAD_0007,     1, 1,   32'h0000_3100, 1, 32'h0000_7000, 32'h0,        1);
    tbl[15] = mk(0,  0,  1, 32'h0000_4180, 32'h0,       1,  32'hDEAD_0008,     1, 0,   32'h0,         0, 32'h0000_3100, 32'h0,        0);
    tbl[16] = mk(0,  0,  0, 32'h0,        32'h0,        0,  32'hDEAD_0009,     1, 1,   32'h0000_4180, 0, 32'h0000_4180, 32'h0,        0);
    tbl[17] = mk(0,  0,  0, 32'h0,        32'h0,        1,  32'hFFFF_4180,     1, 1,   32'h0000_4180, 0, 32'h0000_4180, 32'h0,        0);
    tbl[18] = mk(1,  0,  1, 32'h0000_5000, 32'h0000_4184, 1, 32'hDEAD_000A,    0, 0,   32'h0,         1, 32'h0000_4180, 32'hFFFF_4180, 0);
    tbl[19] = mk(0,  0,  0, 32'h0,        32'h0,        0,  32'hDEAD_000B,     1, 1,   32'h0000_3000, 0, 32'h0000_3000, 32'h0,        0);
    tbl[20] = mk(0,  0,  1, 32'h0000_7000, 32'h0,       0,  32'hDEAD_000C,     1, 0,   32'h0,         0, 32'h0000_3000, 32'h0,        0);
    tbl[21] = mk(0,  0,  0, 32'h0,        32'h0,        1,  32'hDEAD_000D,     1, 0,   32'h0,         0, 32'h0000_7000, 32'h0,        0);
    tbl[22] = mk(0,  1,  0, 32'h0,        32'h0,        1,  32'hDEAD_000E,     1, 0,   32'h0,         1, 32'h0000_7000, 32'h0,        1);
    tbl[23] = mk(0,  0,  0, 32'h0,        32'h0000_6FFC, 1, 32'hFFFF_6FFC,     1, 1,   32'h0000_6FFC, 1, 32'h0000_7000, 32'h0,        1);
    tbl[24] = mk(0,  1,  0, 32'h0,        32'h0,        1,  32'hDEAD_000F,     1, 0,   32'h0,         1, 32'h0000_6FFC, 32'hFFFF_6FFC, 0);
    tbl[25] = mk(0,  0,  0, 32'h0,        32'h0000_2FFC, 1, 32'hDEAD_0010,     1, 0,   32'h0,         1, 32'h0000_6FFC, 32'hFFFF_6FFC, 0);
    tbl[26] = mk(0,  1,  0, 32'h0,        32'h0,        0,  32'hDEAD_0011,     1, 0,   32'h0,         1, 32'h0000_2FFC, 32'h0,        1);

    repeat (2) @(posedge clk);
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < NVEC; i++) begin
      reset = tbl[i].rst; stall = tbl[i].stl; flush = tbl[i].fl;
      flush_pc = tbl[i].fpc; npc = tbl[i].np; imem_ack = tbl[i].ack;
      imem_rdata = tbl[i].rd;
      #1;
      chk("vec_valid", i, {31'd0, F_valid}, {31'd0, tbl[i].evld});
      chk("vec_pc", i, F_pc, tbl[i].epc);
      chk("vec_instr", i, F_instr, tbl[i].einstr);
      chk("vec_adel", i, {31'd0, F_exc_adel}, {31'd0, tbl[i].eadel});
      if (tbl[i].cc) begin
        chk("vec_req", i, {31'd0, imem_req}, {31'd0, tbl[i].ereq});
        if (tbl[i].ereq) chk("vec_addr", i, imem_addr, tbl[i].eaddr);
      end
      @(negedge clk);
    end

    // Randomized traffic against the behavioural model.
    m_vld = 1'b0; m_pc = '0; m_instr = '0; m_adel = 1'b0; m_adel_chk = 1'b0;
    for (int c = 0; c < NRAND; c++) begin
      logic        e_req;
      logic [31:0] e_addr;
      reset      = (c == 0) || ($urandom_range(0, 63) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      flush_pc   = any_pc();
      stall      = ($urandom_range(0, 3) == 0);
      imem_ack   = ($urandom_range(0, 1) == 0);
      imem_rdata = $urandom;
      case ($urandom_range(0, 5))
        0, 1, 2: npc = m_pc + 32'd4;
        3, 4:    npc = legal_pc();
        default: npc = any_pc();
      endcase
      #1;
      if (c > 0) begin
        chk("rnd_valid", c, {31'd0, F_valid}, {31'd0, m_vld});
        chk("rnd_pc", c, F_pc, m_pc);
        chk("rnd_instr", c, F_instr, m_instr);
        if (m_adel_chk) chk("rnd_adel", c, {31'd0, F_exc_adel}, {31'd0, m_adel});
      end

      // Expected request this cycle and F contents after the edge.
      e_req = 1'b0; e_addr = '0;
      if (reset) begin
        m_vld = 1'b0; m_pc = RST_PC; m_instr = '0; m_adel = 1'b0; m_adel_chk = 1'b1;
      end else if (flush) begin
        m_vld = 1'b0; m_pc = flush_pc; m_instr = '0; m_adel = 1'b0; m_adel_chk = 1'b1;
      end else if (!m_vld) begin
        if (is_bad(m_pc)) begin
          m_vld = 1'b1; m_instr = '0; m_adel = 1'b1; m_adel_chk = 1'b1;
        end else begin
          e_req = 1'b1; e_addr = m_pc;
          if (imem_ack) begin
            m_vld = 1'b1; m_instr = imem_rdata; m_adel = 1'b0; m_adel_chk = 1'b1;
          end
        end
      end else if (!stall) begin
        if (is_bad(npc)) begin
          m_pc = npc; m_instr = '0; m_adel = 1'b1; m_adel_chk = 1'b1;
        end else begin
          e_req = 1'b1; e_addr = npc; m_pc = npc;
          if (imem_ack) begin
            m_instr = imem_rdata; m_adel = 1'b0; m_adel_chk = 1'b1;
          end else begin
            m_vld = 1'b0; m_instr = '0; m_adel_chk = 1'b0;
          end
        end
      end

      if (!reset && c > 0) begin
        chk("rnd_req", c, {31'd0, imem_req}, {31'd0, e_req});
        if (e_req) chk("rnd_addr", c, imem_addr, e_addr);
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/f_fetch_seq.md
Name: f_fetch_seq

Overview:
- F-stage fetch sequencer for the 5-stage MIPS pipeline.
- Owns the F-stage PC register and feeds the D-stage next-PC logic.
- Runs a req/ack handshake with the instruction memory and holds the fetched instruction while the hazard unit stalls D.
- On accept, loads the D-stage next-PC result (sequential, branch, j, or jr target; delay-slot semantics are preserved because npc is computed while the slot instruction is in F). Flushes to an exception vector on request.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset.
- IMEM_LO, 32'h0000_3000, lowest legal fetch address.
- IMEM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; samples on posedge clk.
- stall  in  1  hazard unit: D stage cannot accept an F instruction this cycle.
- npc  in  32  next PC from the D-stage next-PC logic; valid whenever F_valid=1.
- flush  in  1  exception or eret redirect.
- flush_pc  in  32  target PC for flush.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ack=0.
- imem_ack  in  1  read data valid this cycle; only meaningful when imem_req=1.
- imem_rdata  in  32  instruction word.
- F_pc  out  32  PC of the instruction held in F.
- F_instr  out  32  held instruction; 0 (nop) when not valid or when faulted.
- F_valid  out  1  F_instr/F_pc are valid for D.
- F_exc_adel  out  1  fetch address error for the held instruction.

Behaviour:
- Handshake definition: accept = F_valid & ~stall & ~flush.
- Memory protocol:
  - The slave has no transaction state, so the master may drop imem_req at any time.
  - Zero-wait ack (ack in the same cycle as req) is legal.
- Address check: bad(a) = (a[1:0]!=0) | (a<IMEM_LO) | (a>IMEM_HI).
- State FETCH: PC register pc_q targets a new instruction; F_valid=0.
  - If bad(pc_q): imem_req=0. Next edge: F_instr<=0, F_exc_adel<=1, F_valid<=1, go to HOLD.
  - Else: imem_req=1, imem_addr=pc_q.
    - On imem_ack: F_instr<=imem_rdata, F_exc_adel<=0, F_valid<=1, go to HOLD.
    - Otherwise stay in FETCH.
- State HOLD: F_valid=1, F_pc=pc_q.
  - If ~accept: imem_req=0; outputs and state hold indefinitely.
  - If accept and bad(npc): imem_req=0. Next edge: pc_q<=npc, F_instr<=0, F_exc_adel<=1, stay in HOLD.
  - If accept and npc is legal: imem_req=1, imem_addr=npc (combinational).
    - On ack: pc_q<=npc, F_instr<=imem_rdata, F_exc_adel<=0, stay in HOLD. This gives 1 instruction/cycle throughput.
    - Without ack: pc_q<=npc, F_valid<=0, F_instr<=0, go to FETCH.
- Flush has priority over accept, ack and stall, in any state.
  - Effect: imem_req=0 that cycle; any ack in that cycle is ignored.
  - Next edge: pc_q<=flush_pc, F_valid<=0, F_instr<=0, F_exc_adel<=0, go to FETCH.
- Reset has priority over everything, including flush and ack.
  - Next edge: pc_q<=RESET_PC, state FETCH, F_valid=0, F_instr=0, F_exc_adel=0.
  - Combinational outputs after reset: imem_req=1 and imem_addr=RESET_PC (RESET_PC is legal).
  - A fetch outstanding at reset is abandoned.
- Outputs:
  - F_pc=pc_q at all times.
  - F_valid is derived from state (HOLD=1).
- PC arithmetic is 32-bit with no wrap detection; wrap is caught by the range check.
- Latency: PC to F_valid is 1 cycle with zero-wait memory, or N+1 cycles for N wait cycles.

Test Plan:
- Release reset, imem acks every cycle with rdata=pc ^ 32'hFFFF0000, npc=F_pc+4, stall=0 -> F_valid rises 1 cycle after reset release; F_pc sequence is 3000, 3004, 3008 on consecutive cycles; F_instr matches.
- Hold stall=1 for 3 cycles while F_valid=1 -> imem_req=0, and F_pc/F_instr are unchanged for those 3 cycles. When stall drops, the next PC equals the npc presented at that cycle (e.g. branch target 3040 after a delay slot at 3008).
- Memory inserts 2 wait cycles per fetch -> imem_addr stays stable across the wait cycles and F_valid=0 in the gap; one instruction every 3 cycles.
- Present npc=3002, then separately npc=7000, on accept -> no imem_req; F_exc_adel=1, F_instr=0, F_valid=1, F_pc=3002 (resp. 7000).
- Assert flush with flush_pc=4180 while in FETCH with imem_ack=1 in the same cycle -> the ack is ignored; the next request is imem_addr=4180 and F_valid=0 for that cycle.
- Assert reset mid-stream with flush=1 and imem_ack=1 -> next cycle F_pc=3000, F_valid=0, F_exc_adel=0, imem_req=1 with imem_addr=3000.
